// File: rtl/spi_ad_slave_if.sv
// rtl/spi_ad_slave_if.sv - SPI pin and register-export bundle for spi_ad_slave
interface spi_ad_slave_if;
  logic         csb;
  logic         sclk;
  logic         sdio_i;
  logic         sdio_o;
  logic         sdio_oe;
  logic [127:0] cfg_regs;
  logic         wr_stb;
  logic [5:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         frame_err;

  modport slave (
    input  csb, sclk, sdio_i,
    output sdio_o, sdio_oe, cfg_regs, wr_stb, wr_addr, wr_data, frame_err
  );

  modport master (
    output csb, sclk, sdio_i,
    input  sdio_o, sdio_oe, cfg_regs, wr_stb, wr_addr, wr_data, frame_err
  );
endinterface

// File: rtl/spi_ad_slave.sv
// rtl/spi_ad_slave.sv - oversampled 3-wire SPI responder with a 16x8 register file
module spi_ad_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  REG0_RST    = 8'h18
) (
  input  logic            clk,
  input  logic            reset,
  spi_ad_slave_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, sdio_sync;
  logic                   csb_d, sclk_d;
  logic                   csb_s, sclk_s, sdio_s;
  logic                   csb_fall, csb_rise, sclk_rise, sclk_fall;

  state_t      state;
  logic [4:0]  bcnt;
  logic [7:0]  rx_sr;
  logic [7:0]  rx_next;
  logic [7:0]  tx_sr;
  logic [7:0]  rd_val;
  logic        is_read;
  logic [5:0]  addr;
  logic        oe_r, sdio_o_r;
  logic        wr_stb_r, frame_err_r;
  logic [5:0]  wr_addr_r;
  logic [7:0]  wr_data_r;
  logic [7:0]  regs [16];

  // csb chain resets low so a frame already running at reset release is never seen as a new fall
  always_ff @(posedge clk) begin
    if (reset) begin
      csb_sync  <= '0;
      sclk_sync <= '0;
      sdio_sync <= '0;
      csb_d     <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], bus.csb};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], bus.sdio_i};
      csb_d     <= csb_s;
      sclk_d    <= sclk_s;
    end
  end

  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync[SYNC_STAGES-1];
  assign csb_fall  = ~csb_s & csb_d;
  assign csb_rise  = csb_s & ~csb_d;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  assign rx_next = {rx_sr[6:0], sdio_s};
  assign rd_val  = (rx_next[5:4] == 2'b00) ? regs[rx_next[3:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bcnt        <= 5'd0;
      rx_sr       <= 8'h00;
      tx_sr       <= 8'h00;
      is_read     <= 1'b0;
      addr        <= 6'd0;
      oe_r        <= 1'b0;
      sdio_o_r    <= 1'b0;
      wr_stb_r    <= 1'b0;
      wr_addr_r   <= 6'd0;
      wr_data_r   <= 8'h00;
      frame_err_r <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= (i == 0) ? REG0_RST : 8'h00;
    end else begin
      wr_stb_r    <= 1'b0;
      frame_err_r <= 1'b0;
      case (state)
        IDLE: begin
          oe_r <= 1'b0;
          if (csb_fall) begin
            state <= INSTR;
            bcnt  <= 5'd0;
            rx_sr <= 8'h00;
          end
        end
        INSTR, DATA: begin
          if (csb_rise) begin
            state       <= IDLE;
            oe_r        <= 1'b0;
            frame_err_r <= 1'b1;
          end else if (sclk_rise) begin
            rx_sr <= rx_next;
            bcnt  <= bcnt + 5'd1;
            if (state == INSTR && bcnt == 5'd7) begin
              is_read <= rx_next[7];
              addr    <= rx_next[5:0];
              tx_sr   <= rd_val;
              state   <= DATA;
            end else if (state == DATA && bcnt == 5'd15) begin
              state <= DONE;
              if (!is_read) begin
                wr_stb_r  <= 1'b1;
                wr_addr_r <= addr;
                wr_data_r <= rx_next;
                if (addr[5:4] == 2'b00) regs[addr[3:0]] <= rx_next;
              end
            end
          end else if (sclk_fall && state == DATA && is_read) begin
            oe_r     <= 1'b1;
            sdio_o_r <= tx_sr[7];
            tx_sr    <= {tx_sr[6:0], 1'b0};
          end
        end
        DONE: begin
          if (csb_rise) begin
            state <= IDLE;
            oe_r  <= 1'b0;
          end else if (sclk_fall) begin
            oe_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cfg_regs = '0;
    for (int n = 0; n < 16; n++) bus.cfg_regs[8*n +: 8] = regs[n];
  end

  // gating with csb_s drops the driver in the cycle the abort is seen, not one later
  assign bus.sdio_oe   = oe_r & ~csb_s;
  assign bus.sdio_o    = sdio_o_r;
  assign bus.wr_stb    = wr_stb_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_ad_slave.sv
// tb/tb_spi_ad_slave.sv - scoreboard bench for spi_ad_slave with a register-file reference model
`timescale 1ns/1ps
module tb_spi_ad_slave;

  localparam int HALF = 6;

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    bit         chk;
    bit         rd;
    logic [7:0] d;
  } frm_t;

  logic clk = 1'b0;
  logic reset;
  spi_ad_slave_if bus ();

  spi_ad_slave dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int ferr_cnt = 0;
  int ferr_exp = 0;
  bit mon_en = 1'b0;
  logic [7:0] mdl [16];
  wr_t  exp_wr [$];
  frm_t exp_frm [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_pack();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = mdl[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = (i == 0) ? 8'h18 : 8'h00;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // write-strobe and frame-error monitor
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.wr_stb === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("wr_stb_unexpected", 1, 0);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", bus.wr_addr, e.a);
        check("wr_data", bus.wr_data, e.d);
      end
    end
  end

  // SDIO monitor: collects driven bits at SCLK rises, scores the frame when csb rises
  int nb = 0;
  logic [7:0] rval = 8'h00;
  always @(posedge bus.sclk or posedge bus.csb) begin
    if (bus.csb === 1'b1) begin
      if (mon_en) begin
        if (exp_frm.size() == 0) begin
          check("frame_unexpected", 1, 0);
        end else begin
          frm_t f;
          f = exp_frm.pop_front();
          if (f.chk) begin
            check("oe_bits", nb, f.rd ? 8 : 0);
            if (f.rd) check("rd_data", rval, f.d);
          end
        end
      end
      nb = 0;
      rval = 8'h00;
    end else if (bus.sdio_oe === 1'b1) begin
      rval = {rval[6:0], bus.sdio_o};
      nb++;
    end
  end

  task automatic spi_frame(input logic [15:0] w, input int nclk);
    bus.csb = 1'b0;
    tick(6);
    for (int i = 0; i < nclk; i++) begin
      bus.sdio_i = (i < 16) ? w[15-i] : 1'($urandom);
      tick(HALF);
      bus.sclk = 1'b1;
      tick(HALF);
      bus.sclk = 1'b0;
    end
    tick(HALF);
    bus.csb = 1'b1;
    tick(8);
    check("frame_err_cnt", ferr_cnt, ferr_exp);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input int nclk);
    wr_t e;
    frm_t f;
    e.a = a; e.d = d;
    exp_wr.push_back(e);
    f.chk = 1; f.rd = 0; f.d = 8'h00;
    exp_frm.push_back(f);
    if (a < 16) mdl[a[3:0]] = d;
    spi_frame({2'b00, a, d}, nclk);
    check("cfg_regs", bus.cfg_regs, model_pack());
  endtask

  task automatic do_read(input logic [5:0] a);
    frm_t f;
    f.chk = 1; f.rd = 1;
    f.d = (a < 16) ? mdl[a[3:0]] : 8'h00;
    exp_frm.push_back(f);
    spi_frame({2'b10, a, 8'h00}, 16);
  endtask

  task automatic abort_write(input logic [5:0] a, input logic [7:0] d, input int nclk);
    frm_t f;
    f.chk = 1; f.rd = 0; f.d = 8'h00;
    exp_frm.push_back(f);
    ferr_exp++;
    spi_frame({2'b00, a, d}, nclk);
    check("cfg_regs_abort", bus.cfg_regs, model_pack());
  endtask

  task automatic reset_mid_read(input logic [5:0] a);
    frm_t f;
    f.chk = 0; f.rd = 1; f.d = 8'h00;
    exp_frm.push_back(f);
    bus.csb = 1'b0;
    tick(6);
    for (int i = 0; i < 11; i++) begin
      bus.sdio_i = (i == 0) ? 1'b1 : ((i >= 2 && i < 8) ? a[7-i] : 1'b0);
      tick(HALF);
      bus.sclk = 1'b1;
      tick(HALF);
      bus.sclk = 1'b0;
    end
    tick(2);
    check("oe_before_reset", bus.sdio_oe, 1);
    reset = 1'b1;
    tick(1);
    check("oe_after_reset", bus.sdio_oe, 0);
    reset = 1'b0;
    model_reset();
    tick(3);
    bus.csb = 1'b1;
    tick(10);
    check("cfg_regs_after_reset", bus.cfg_regs, model_pack());
    check("frame_err_reset", ferr_cnt, ferr_exp);
  endtask

  initial begin
    logic [7:0] init_vals [10];
    logic [5:0] init_addrs [10];
    bus.csb = 1'b1;
    bus.sclk = 1'b0;
    bus.sdio_i = 1'b0;
    reset = 1'b1;
    model_reset();
    tick(5);
    check("rst_cfg_regs", bus.cfg_regs, model_pack());
    check("rst_reg0", bus.cfg_regs[7:0], 8'h18);
    check("rst_sdio_oe", bus.sdio_oe, 0);
    check("rst_sdio_o", bus.sdio_o, 0);
    check("rst_wr_stb", bus.wr_stb, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_frame_err", bus.frame_err, 0);
    reset = 1'b0;
    tick(10);
    mon_en = 1'b1;

    do_write(6'h08, 8'h20, 16);
    do_write(6'h0D, 8'hFF, 16);
    check("reg08", bus.cfg_regs[71:64], 8'h20);
    check("reg0d", bus.cfg_regs[111:104], 8'hFF);

    init_addrs = '{6'h00, 6'h01, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    init_vals  = '{8'h3C, 8'h81, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h7E, 8'hC3, 8'h0F, 8'hF0};
    for (int i = 0; i < 10; i++) do_write(init_addrs[i], init_vals[i], 16);
    for (int i = 0; i < 10; i++) do_read(init_addrs[i]);

    do_read(6'h3F);
    do_write(6'h20, 8'h55, 16);
    abort_write(6'h09, 8'h77, 11);
    check("reg09_kept", bus.cfg_regs[79:72], 8'hA5);
    do_write(6'h0A, 8'hC3, 20);
    do_read(6'h0A);

    reset_mid_read(6'h00);
    do_write(6'h05, 8'hA5, 16);
    do_read(6'h05);
    do_read(6'h00);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] a;
      logic [7:0] d;
      a = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(16, 63));
      d = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0, 1, 2: do_write(a, d, 16);
        3, 4:    do_read(a);
        default: abort_write(a, d, $urandom_range(1, 15));
      endcase
    end

    tick(20);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("frame_queue_empty", exp_frm.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
